// File: rtl/button_conditioner_if.sv
// Key-conditioner bus: raw board keys in, debounced levels and
// single-cycle increment/confirm pulses out.
interface button_conditioner_if;
  logic [3:0] keys_raw;
  logic [2:0] pushbuttons;
  logic       confirm;
  logic [3:0] key_level;

  modport master (
    output keys_raw,
    input  pushbuttons,
    input  confirm,
    input  key_level
  );

  modport slave (
    input  keys_raw,
    output pushbuttons,
    output confirm,
    output key_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects four board keys; digit keys
// [2:0] auto-repeat while held, the confirm key [3] pulses once per press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 restart,
  button_conditioner_if.slave  bus
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [3:0]       REPEAT_EN  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0]       w_raw_pressed;
  logic [3:0]       r_sync_p0;
  logic [3:0]       r_sync_p1;
  logic [DB_W-1:0]  r_db_cnt [4];
  logic [3:0]       r_level;
  logic [3:0]       w_rise;
  logic [3:0]       w_fall;
  state_t           r_state     [4];
  state_t           w_state_nxt [4];
  logic [RPT_W-1:0] r_rpt_cnt   [4];
  logic [RPT_W-1:0] w_rpt_nxt   [4];
  logic [3:0]       w_pulse;
  logic [3:0]       r_pulse;

  assign w_raw_pressed = ACTIVE_LOW ? ~bus.keys_raw : bus.keys_raw;

  // Two-flop synchronizer
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw_pressed;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Debounce: any return to the current level clears the count
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_level <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync_p1[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= ~r_level[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Flip events are decoded one cycle early so the press pulse lines up with key_level
  always_comb begin
    w_rise = '0;
    w_fall = '0;
    for (int i = 0; i < 4; i++) begin
      if ((r_sync_p1[i] != r_level[i]) && (r_db_cnt[i] == DB_LAST)) begin
        w_rise[i] = r_sync_p1[i];
        w_fall[i] = ~r_sync_p1[i];
      end
    end
  end

  // Per-channel press/repeat state machine
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        r_state[i]   <= IDLE;
        r_rpt_cnt[i] <= '0;
      end
    end else begin
      r_pulse <= w_pulse;
      for (int i = 0; i < 4; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_rpt_cnt[i] <= w_rpt_nxt[i];
      end
    end
  end

  always_comb begin
    w_pulse = '0;
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      w_rpt_nxt[i]   = r_rpt_cnt[i];
      case (r_state[i])
        IDLE: begin
          if (w_rise[i]) begin
            w_pulse[i]     = 1'b1;
            w_rpt_nxt[i]   = RPT_DELAY;
            w_state_nxt[i] = HELD;
          end
        end
        HELD: begin
          if (w_fall[i]) begin
            w_rpt_nxt[i]   = '0;
            w_state_nxt[i] = IDLE;
          end else if (r_rpt_cnt[i] != '0) begin
            w_rpt_nxt[i] = r_rpt_cnt[i] - RPT_ONE;
          end else if (REPEAT_EN[i]) begin
            w_pulse[i]     = 1'b1;
            w_rpt_nxt[i]   = RPT_PERIOD;
            w_state_nxt[i] = REPEAT;
          end
        end
        REPEAT: begin
          // Release outranks a coincident repeat expiry
          if (w_fall[i]) begin
            w_rpt_nxt[i]   = '0;
            w_state_nxt[i] = IDLE;
          end else if (r_rpt_cnt[i] != '0) begin
            w_rpt_nxt[i] = r_rpt_cnt[i] - RPT_ONE;
          end else begin
            w_pulse[i]   = 1'b1;
            w_rpt_nxt[i] = RPT_PERIOD;
          end
        end
        default: begin
          w_rpt_nxt[i]   = '0;
          w_state_nxt[i] = IDLE;
        end
      endcase
    end
  end

  assign bus.pushbuttons = r_pulse[2:0];
  assign bus.confirm     = r_pulse[3];
  assign bus.key_level   = r_level;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the number-guessing datapath. It synchronizes, debounces and edge-detects the raw board keys, and drives the single-cycle increment pulses (`pushbuttons`) and the `confirm` pulse consumed by the digit-entry stage. Each digit key also auto-repeats while held, so a held key steps its digit at a controlled rate instead of once per clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles a synchronized key must differ from its debounced level before the level flips (10 ms at 50 MHz). Minimum 2.
- `REPEAT_DELAY`, default 25000000: cycles from the debounced press to the first auto-repeat pulse. Minimum 2.
- `REPEAT_PERIOD`, default 10000000: cycles between later auto-repeat pulses. Minimum 2.
- `ACTIVE_LOW`, default 1: 1 means a key reads 0 when pressed. The raw input is inverted before the synchronizer.

Ports:
- `clk`, input, 1 bit: system clock.
- `restart`, input, 1 bit: reset, asynchronous and active-high.
- `keys_raw`, input, 4 bits: asynchronous board keys. Bits [2:0] are digit 1..3 and bit [3] is confirm.
- `pushbuttons`, output, 3 bits: single-cycle increment pulses for digits 1..3.
- `confirm`, output, 1 bit: single-cycle confirm pulse. It never auto-repeats.
- `key_level`, output, 4 bits: debounced pressed level per key (1 = pressed).

## Operation
- Each of the 4 channels is independent and identical, except that channel 3 has auto-repeat disabled.
- Synchronizer:
  - Two flip-flops per channel.
  - The polarity inversion (when `ACTIVE_LOW` = 1) happens before the first flip-flop.
- Debounce:
  - One counter per channel, width $clog2(DEBOUNCE_CYCLES).
  - When the synchronized value equals `key_level`, the counter holds 0.
  - When they differ, the counter increments.
  - When they differ and the counter equals DEBOUNCE_CYCLES-1, `key_level` toggles and the counter clears.
  - Any bounce back to the current level clears the counter, so glitches shorter than DEBOUNCE_CYCLES are never seen.
- Per-channel state machine. States IDLE, HELD, REPEAT:
  - IDLE: `key_level` is 0. On the debounced 0→1 flip, emit a pulse, load the repeat counter with REPEAT_DELAY-1, and go to HELD.
  - HELD: the repeat counter decrements each cycle.
    - When it reaches 0, emit a pulse, load REPEAT_PERIOD-1, and go to REPEAT.
    - For channel 3, HELD never leaves on the counter; it waits for release only.
  - REPEAT: the counter decrements. When it reaches 0, emit a pulse and reload REPEAT_PERIOD-1.
  - From HELD or REPEAT, the debounced 1→0 flip returns to IDLE with no pulse. The repeat counter is cleared.
- Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- All outputs are registered. A pulse is high for exactly one cycle.
- Simultaneous events:
  - Channels never block each other. Pulses on several outputs in the same cycle are legal and passed through.
  - The downstream stage handles that case.
- Release and repeat in the same cycle: if release and the repeat counter reaching 0 happen in the same cycle, release wins and no pulse is emitted.

## Timing
- Reset values, asynchronous on `restart` = 1:
  - Synchronizers, debounce counters and repeat counters are 0.
  - All states are IDLE.
  - `key_level` = 4'b0000, `pushbuttons` = 3'b000, `confirm` = 0.
- Press latency:
  - Take a raw edge that is stable before clock edge E.
  - `key_level` and the press pulse both rise after edge E+1+DEBOUNCE_CYCLES.
  - So the pulse is high during the cycle following that edge.
- Release latency: `key_level` falls DEBOUNCE_CYCLES+2 edges after a stable raw release.
- First repeat pulse: REPEAT_DELAY cycles after the press pulse. Later repeat pulses are REPEAT_PERIOD cycles apart.
- Reset while a key is held:
  - Everything clears, including `key_level` = 0.
  - After `restart` falls, the held key is re-debounced and yields a fresh press pulse DEBOUNCE_CYCLES+2 edges later.

## Test plan
Use DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3 and ACTIVE_LOW = 1 unless stated.
- Clean press: `keys_raw[0]` goes 1→0 and is held for 8 cycles.
  - `pushbuttons[0]` is high for exactly 1 cycle, 6 edges after the change.
  - `key_level[0]` = 1.
  - No second pulse.
- Bounce rejection: `keys_raw[1]` toggles every 2 cycles for 20 cycles, then returns to 1.
  - `pushbuttons[1]` stays 0 throughout.
  - `key_level[1]` stays 0 throughout.
- Auto-repeat: `keys_raw[2]` is held pressed for 30 cycles after the press pulse.
  - Pulses occur at offsets 0, 10, 13, 16, 19, 22, 25 and 28 from the press pulse.
  - Release then produces no pulse.
- Confirm has no repeat: `keys_raw[3]` is held for 40 cycles.
  - `confirm` pulses exactly once.
  - `key_level[3]` stays 1 until 6 edges after release.
- Simultaneous keys: `keys_raw[0]` and `keys_raw[3]` are pressed on the same cycle.
  - `pushbuttons[0]` and `confirm` pulse in the same cycle.
- Reset mid-hold: assert `restart` for 1 cycle during REPEAT on channel 0, with the key still held.
  - All outputs go to 0 immediately.
  - A new press pulse appears 6 edges after `restart` falls.
  - Repeat timing then restarts with REPEAT_DELAY.
